hgcal_fc_manager_bxsched: RTL and testbench

Multi-channel, parametrised BX-timed command scheduler for the fast-control encoder manager. Each of NCH channels holds a pending request (periodic, synchronous, or asynchronous) and fires a one-cycle pulse when the orbit BX counter reaches that channel's target. Same-BX conflicts are resolved by fixed priority. It generalises the two-channel orbit-sync/OCR pairing to any number of command slots, each with its own target, mode and orbit prescale.

---
 rtl/hgcal_fc_pkg.sv | 18 +
 rtl/hgcal_fc_manager_bxslot.sv | 104 ++++++++++
 rtl/hgcal_fc_manager_bxsched.sv | 100 ++++++++++
 tb/tb_hgcal_fc_manager_bxsched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hgcal_fc_pkg.sv
// Shared definitions for the fast-control encoder manager BX scheduler.
// Contents:
//   mode_e       per-channel command mode encoding
//   BXW_DEFAULT  default BX counter width
//   FIRE_ID_W    width of the firing-channel index output
package hgcal_fc_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_REQUEST  = 2'b10,
        MODE_BOTH     = 2'b11
    } mode_e;

    localparam int unsigned BXW_DEFAULT = 12;
    localparam int unsigned FIRE_ID_W   = 4;

endpackage

// File: rtl/hgcal_fc_manager_bxslot.sv
// One command channel of the BX scheduler.
// Ports:
//   clk40, reset       clock, asynchronous active-high reset
//   enable             global enable; low clears pending and the prescale counter
//   bx_now, bx_target  current BX and this channel's target BX
//   mode               channel mode (see hgcal_fc_pkg::mode_e)
//   prescale           periodic channel fires every prescale+1 orbits
//   request_40         clk40-synchronous single-cycle request
//   request_async      asynchronous level request, rising edge counts
//   grant              this channel won arbitration this cycle
//   pending            request armed, not yet fired
//   match              channel wants to fire this cycle
//   lost               channel matched but did not win arbitration
module hgcal_fc_manager_bxslot
    import hgcal_fc_pkg::*;
#(
    parameter int unsigned BXW         = BXW_DEFAULT,
    parameter int unsigned PSW         = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk40,
    input  logic           reset,
    input  logic           enable,
    input  logic [BXW-1:0] bx_now,
    input  logic [BXW-1:0] bx_target,
    input  logic [1:0]     mode,
    input  logic [PSW-1:0] prescale,
    input  logic           request_40,
    input  logic           request_async,
    input  logic           grant,
    output logic           pending,
    output logic           match,
    output logic           lost
);

    mode_e                  mode_q;
    logic                   active;
    logic                   periodic_en;
    logic                   request_en;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   async_prev;
    logic                   async_req;
    logic [PSW-1:0]         ps_cnt;
    logic                   orbit_start;
    logic                   arm;
    logic                   req_now;
    logic                   want;

    assign mode_q      = mode_e'(mode);
    assign active      = enable & (mode_q != MODE_OFF);
    assign periodic_en = enable & ((mode_q == MODE_PERIODIC) | (mode_q == MODE_BOTH));
    assign request_en  = enable & ((mode_q == MODE_REQUEST)  | (mode_q == MODE_BOTH));
    assign orbit_start = (bx_now == '0);

    // Synchroniser, then a registered rising-edge detect so an asynchronous
    // request reaches req_now SYNC_STAGES+1 cycles after it is first sampled.
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            async_prev <= 1'b0;
            async_req  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], request_async};
            async_prev <= sync_q[SYNC_STAGES-1];
            async_req  <= sync_q[SYNC_STAGES-1] & ~async_prev;
        end
    end

    // Arming at the orbit boundary is folded into the match term so a
    // target of BX 0 fires in the same orbit it was armed.
    assign arm     = periodic_en & orbit_start & (ps_cnt == '0);
    assign req_now = request_en & (request_40 | async_req);
    assign want    = pending | arm | req_now;
    assign match   = active & want & (bx_now == bx_target);
    assign lost    = match & ~grant;

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            ps_cnt <= '0;
        end else if (!periodic_en) begin
            ps_cnt <= '0;
        end else if (orbit_start) begin
            if (ps_cnt == '0) begin
                ps_cnt <= prescale;
            end else begin
                ps_cnt <= ps_cnt - 1'b1;
            end
        end
    end

    // Coalescing: a new request while pending simply leaves pending set.
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (!active) begin
            pending <= 1'b0;
        end else if (grant) begin
            pending <= 1'b0;
        end else if (want) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/hgcal_fc_manager_bxsched.sv
// Multi-channel BX-timed command scheduler for the fast-control encoder
// manager. Each channel fires a one-cycle pulse when bx_now reaches its
// target; same-BX conflicts go to the lowest channel index.
// Ports:
//   clk40, reset     40 MHz clock, asynchronous active-high reset
//   enable           global enable
//   bx_now           current BX; orbit boundary at 0
//   bx_target        per-channel target BX, channel i at [i*BXW +: BXW]
//   mode             per-channel 2-bit mode
//   prescale         per-channel orbit prescale
//   request_40       clk40-synchronous requests
//   request_async    asynchronous level requests
//   clear_status     clears collision sticky bits (a same-cycle set wins)
//   pending          per-channel armed flag
//   fire             registered one-hot fire pulse
//   fire_any         OR of fire
//   fire_id          index of firing channel, 0 when none
//   collision        sticky lost-arbitration flags
module hgcal_fc_manager_bxsched
    import hgcal_fc_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned BXW         = BXW_DEFAULT,
    parameter int unsigned PSW         = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk40,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [BXW-1:0]       bx_now,
    input  logic [NCH*BXW-1:0]   bx_target,
    input  logic [NCH*2-1:0]     mode,
    input  logic [NCH*PSW-1:0]   prescale,
    input  logic [NCH-1:0]       request_40,
    input  logic [NCH-1:0]       request_async,
    input  logic                 clear_status,
    output logic [NCH-1:0]       pending,
    output logic [NCH-1:0]       fire,
    output logic                 fire_any,
    output logic [FIRE_ID_W-1:0] fire_id,
    output logic [NCH-1:0]       collision
);

    logic [NCH-1:0]       match;
    logic [NCH-1:0]       lost;
    logic [NCH-1:0]       grant;
    logic [FIRE_ID_W-1:0] win_id;
    logic                 found;

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        hgcal_fc_manager_bxslot #(
            .BXW         (BXW),
            .PSW         (PSW),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_slot (
            .clk40         (clk40),
            .reset         (reset),
            .enable        (enable),
            .bx_now        (bx_now),
            .bx_target     (bx_target[i*BXW +: BXW]),
            .mode          (mode[i*2 +: 2]),
            .prescale      (prescale[i*PSW +: PSW]),
            .request_40    (request_40[i]),
            .request_async (request_async[i]),
            .grant         (grant[i]),
            .pending       (pending[i]),
            .match         (match[i]),
            .lost          (lost[i])
        );
    end

    // Fixed priority: lowest matching index wins.
    always_comb begin
        grant  = '0;
        win_id = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (match[i] && !found) begin
                grant[i] = 1'b1;
                win_id   = FIRE_ID_W'(i);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            fire      <= '0;
            fire_any  <= 1'b0;
            fire_id   <= '0;
            collision <= '0;
        end else begin
            fire      <= grant;
            fire_any  <= found;
            fire_id   <= win_id;
            collision <= (clear_status ? '0 : collision) | lost;
        end
    end

endmodule

// File: tb/tb_hgcal_fc_manager_bxsched.sv
`timescale 1ns/1ps
module tb_hgcal_fc_manager_bxsched;

    localparam int NCH   = 4;
    localparam int BXW   = 12;
    localparam int PSW   = 8;
    localparam int SS    = 2;
    localparam int ORBIT = 3564;

    logic               clk40 = 1'b0;
    logic               reset;
    logic               enable;
    logic [BXW-1:0]     bx_now;
    logic [NCH*BXW-1:0] bx_target;
    logic [NCH*2-1:0]   mode;
    logic [NCH*PSW-1:0] prescale;
    logic [NCH-1:0]     request_40;
    logic [NCH-1:0]     request_async;
    logic               clear_status;
    logic [NCH-1:0]     pending;
    logic [NCH-1:0]     fire;
    logic               fire_any;
    logic [3:0]         fire_id;
    logic [NCH-1:0]     collision;

    int errors = 0;
    int checks = 0;
    int orbit  = 0;
    int fire_cnt [NCH];
    int q1 [$];

    always #12.5 clk40 = ~clk40;

    hgcal_fc_manager_bxsched #(
        .NCH         (NCH),
        .BXW         (BXW),
        .PSW         (PSW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk40         (clk40),
        .reset         (reset),
        .enable        (enable),
        .bx_now        (bx_now),
        .bx_target     (bx_target),
        .mode          (mode),
        .prescale      (prescale),
        .request_40    (request_40),
        .request_async (request_async),
        .clear_status  (clear_status),
        .pending       (pending),
        .fire          (fire),
        .fire_any      (fire_any),
        .fire_id       (fire_id),
        .collision     (collision)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t bx=%0d orbit=%0d: got %0h expected %0h",
                     name, $time, bx_now, orbit, act, exp);
        end
    endtask

    // Reference model: orbit-count modulo for prescale, sample history for
    // the asynchronous request path, lowest-index winner per BX.
    logic [NCH-1:0]  m_pend, m_fire, m_coll;
    logic            m_any;
    logic [3:0]      m_fid;
    int              m_n [NCH];
    logic [SS+1:0]   m_hist [NCH];

    always @(posedge clk40 or posedge reset) begin
        logic [NCH-1:0] want, hit;
        logic [1:0] md;
        logic on, arm, req, aedge;
        int win, ps;
        if (reset) begin
            m_pend = '0; m_fire = '0; m_coll = '0; m_any = 1'b0; m_fid = '0;
            for (int c = 0; c < NCH; c++) begin
                m_n[c] = 0;
                m_hist[c] = '0;
            end
        end else begin
            win = -1;
            for (int c = 0; c < NCH; c++) begin
                md    = mode[c*2 +: 2];
                ps    = int'(prescale[c*PSW +: PSW]);
                on    = enable && (md != 2'b00);
                arm   = on && md[0] && (bx_now == 0) && (m_n[c] % (ps + 1) == 0);
                aedge = m_hist[c][SS] && !m_hist[c][SS+1];
                req   = on && md[1] && (request_40[c] || aedge);
                want[c] = m_pend[c] || arm || req;
                hit[c]  = on && want[c] && (bx_now == bx_target[c*BXW +: BXW]);
                if (hit[c] && win < 0) win = c;
            end
            m_fire = '0;
            if (win >= 0) m_fire[win] = 1'b1;
            m_any = (win >= 0);
            m_fid = (win >= 0) ? win[3:0] : 4'd0;
            if (clear_status) m_coll = '0;
            for (int c = 0; c < NCH; c++) begin
                md = mode[c*2 +: 2];
                on = enable && (md != 2'b00);
                if (hit[c] && c != win) m_coll[c] = 1'b1;
                if (!on || c == win) m_pend[c] = 1'b0;
                else if (want[c])   m_pend[c] = 1'b1;
                if (!(enable && md[0])) m_n[c] = 0;
                else if (bx_now == 0)   m_n[c] = m_n[c] + 1;
                m_hist[c] = {m_hist[c][SS:0], request_async[c]};
            end
        end
    end

    always @(posedge clk40) begin
        #2;
        chk("fire", fire, m_fire);
        chk("fire_any", fire_any, m_any);
        chk("fire_id", fire_id, m_fid);
        chk("pending", pending, m_pend);
        chk("collision", collision, m_coll);
        for (int c = 0; c < NCH; c++) if (fire[c] === 1'b1) fire_cnt[c]++;
        if (fire[1] === 1'b1) q1.push_back(orbit);
    end

    task automatic step();
        @(negedge clk40);
        request_40   = '0;
        clear_status = 1'b0;
        if (bx_now == BXW'(ORBIT - 1)) begin
            bx_now = '0;
            orbit++;
        end else begin
            bx_now = bx_now + 1'b1;
        end
    endtask

    task automatic run_to(input int b);
        do step(); while (bx_now != BXW'(b));
    endtask

    task automatic do_reset();
        @(negedge clk40);
        reset = 1'b1; enable = 1'b0; mode = '0; prescale = '0; bx_target = '0;
        request_40 = '0; request_async = '0; clear_status = 1'b0; bx_now = '0;
        repeat (2) @(negedge clk40);
        reset = 1'b0;
        orbit = 0;
    endtask

    int c0 [NCH];

    initial begin
        reset = 1'b1; enable = 1'b0; bx_now = '0; bx_target = '0; mode = '0;
        prescale = '0; request_40 = '0; request_async = '0; clear_status = 1'b0;
        for (int c = 0; c < NCH; c++) fire_cnt[c] = 0;

        // Periodic: ch0 every orbit at BX 100
        do_reset();
        chk("rst_fire", fire, 4'b0000);
        chk("rst_pending", pending, 4'b0000);
        chk("rst_collision", collision, 4'b0000);
        chk("rst_fire_id", fire_id, 4'd0);
        mode[1:0] = 2'b01; bx_target[0 +: BXW] = 12'd100; enable = 1'b1;
        for (int c = 0; c < NCH; c++) c0[c] = fire_cnt[c];
        run_to(101);
        chk("per_fire", fire, 4'b0001);
        chk("per_fire_id", fire_id, 4'd0);
        chk("per_fire_any", fire_any, 1'b1);
        while (orbit < 3) step();
        chk("per_cnt0", fire_cnt[0] - c0[0], 3);
        chk("per_cnt_others", fire_cnt[1] + fire_cnt[2] + fire_cnt[3] - c0[1] - c0[2] - c0[3], 0);

        // Prescale: ch1 prescale 2, target 50 -> orbits 0, 3, 6
        do_reset();
        mode[3:2] = 2'b01; prescale[PSW +: PSW] = 8'd2; bx_target[BXW +: BXW] = 12'd50;
        enable = 1'b1;
        q1.delete();
        while (orbit < 7) begin
            step();
            if (bx_now == 1) chk("ps_pend_bx1", pending[1], (orbit % 3) == 0);
        end
        chk("ps_nfires", q1.size(), 3);
        if (q1.size() == 3) begin
            chk("ps_orbit_a", q1[0], 0);
            chk("ps_orbit_b", q1[1], 3);
            chk("ps_orbit_c", q1[2], 6);
        end

        // Async: ch2 request-driven, target 1000, two pulses in one orbit
        do_reset();
        mode[5:4] = 2'b10; bx_target[2*BXW +: BXW] = 12'd1000; enable = 1'b1;
        c0[2] = fire_cnt[2];
        run_to(500); request_async[2] = 1'b1;
        run_to(508); request_async[2] = 1'b0;
        run_to(510);
        chk("as_pending", pending, 4'b0100);
        run_to(700); request_async[2] = 1'b1;
        run_to(708); request_async[2] = 1'b0;
        run_to(1001);
        chk("as_fire", fire, 4'b0100);
        chk("as_fire_id", fire_id, 4'd2);
        while (orbit < 2) step();
        chk("as_cnt", fire_cnt[2] - c0[2], 1);

        // Collision: ch0 and ch3 both target 10
        do_reset();
        mode = 8'b10_00_00_10;
        bx_target[0 +: BXW] = 12'd10; bx_target[3*BXW +: BXW] = 12'd10;
        enable = 1'b1;
        run_to(5); request_40 = 4'b1001;
        run_to(11);
        chk("col_fire0", fire, 4'b0001);
        chk("col_sticky", collision, 4'b1000);
        chk("col_pend3", pending, 4'b1000);
        run_to(11);
        chk("col_fire3", fire, 4'b1000);
        chk("col_fire_id3", fire_id, 4'd3);
        chk("col_held", collision, 4'b1000);
        run_to(20); clear_status = 1'b1;
        step();
        chk("col_cleared", collision, 4'b0000);
        run_to(10); request_40 = 4'b1001; clear_status = 1'b1;
        step();
        chk("col_same_cycle_fire", fire, 4'b0001);
        chk("col_set_wins", collision, 4'b1000);
        run_to(11);
        chk("col_retry_fire", fire, 4'b1000);

        // Enable drop, mode off, and asynchronous reset during a fire
        mode = 8'b00_00_10_10;
        bx_target[0 +: BXW] = 12'd2200; bx_target[BXW +: BXW] = 12'd2000;
        bx_target[2*BXW +: BXW] = 12'd300;
        for (int c = 0; c < NCH; c++) c0[c] = fire_cnt[c];
        run_to(100); request_40 = 4'b0010;
        run_to(300); request_40 = 4'b0100;
        step();
        chk("off_pending", pending, 4'b0010);
        chk("off_fire", fire, 4'b0000);
        run_to(500); enable = 1'b0;
        step();
        chk("en_pending", pending, 4'b0000);
        chk("en_coll_kept", collision, 4'b1000);
        enable = 1'b1;
        run_to(2100);
        chk("en_no_fire1", fire_cnt[1] - c0[1], 0);
        chk("off_no_fire2", fire_cnt[2] - c0[2], 0);
        run_to(2150); request_40 = 4'b0001;
        run_to(2201);
        chk("rf_fire", fire, 4'b0001);
        #5 reset = 1'b1;
        #1;
        chk("rf_fire_clr", fire, 4'b0000);
        chk("rf_any_clr", fire_any, 1'b0);
        chk("rf_id_clr", fire_id, 4'd0);
        chk("rf_coll_clr", collision, 4'b0000);
        chk("rf_pend_clr", pending, 4'b0000);
        @(negedge clk40);
        @(negedge clk40);
        reset = 1'b0;
        repeat (3) @(negedge clk40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
